// File: rtl/ser_xfer_pkg.sv
// Shared definitions for the BIST serial transfer controller: state encoding
// and the default word width.
package ser_xfer_pkg;

    localparam int WD_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/ser_xfer_ctrl.sv
// Sequences one parallel-to-serial transfer through the BIST shifter/chain and
// assembles the returning chain bits into a parallel response with an ack pulse.
module ser_xfer_ctrl
    import ser_xfer_pkg::*;
#(
    parameter int WD    = WD_DEFAULT,
    parameter int CNT_W = $clog2(WD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [WD-1:0] cmd_data,
    output logic          busy,
    output logic          ack,
    output logic [WD-1:0] rsp_data,
    output logic          ser_load,
    output logic          ser_shift,
    output logic [WD-1:0] ser_load_data,
    input  logic          chain_so
);

    xfer_state_e      state_r;
    xfer_state_e      state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WD-1:0]    rx_r;
    logic [WD-1:0]    rx_next_s;
    logic             last_bit_s;

    assign last_bit_s = (cnt_r == CNT_W'(WD - 1));
    // LSB-first: the shifter emits bit0 first, so it ends up in rx[0].
    assign rx_next_s  = {chain_so, rx_r[WD-1:1]};

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                state_next_s = SHIFT;
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Outputs registered from the next-state decode so they align with the state flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            ack       <= 1'b0;
            ser_load  <= 1'b0;
            ser_shift <= 1'b0;
        end else begin
            busy      <= (state_next_s != IDLE);
            ack       <= (state_next_s == DONE);
            ser_load  <= (state_next_s == LOAD);
            ser_shift <= (state_next_s == SHIFT);
        end
    end

    // Bit counter: cleared in LOAD, advances per shift, parks on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_r == LOAD) begin
            cnt_r <= '0;
        end else if ((state_r == SHIFT) && !last_bit_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Receive shift register capturing chain_so on every shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_r <= '0;
        end else if (state_r == SHIFT) begin
            rx_r <= rx_next_s;
        end
    end

    // Response word takes the completed capture on the last shift edge, so it
    // is already valid in the DONE/ack cycle and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
        end else if ((state_r == SHIFT) && last_bit_s) begin
            rsp_data <= rx_next_s;
        end
    end

    // Shifter load value changes only when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_load_data <= '0;
        end else if ((state_r == IDLE) && req) begin
            ser_load_data <= cmd_data;
        end
    end

endmodule

// File: tb/tb_ser_xfer_ctrl.sv
// Bench for ser_xfer_ctrl: a 32-bit and an 8-bit instance, table vectors,
// hand-written corner sequences and randomized transfers against a bit-list model.
module tb_ser_xfer_ctrl;
    import ser_xfer_pkg::*;

    localparam int M_LOOP = 0;
    localparam int M_ONE  = 1;
    localparam int M_ZERO = 2;
    localparam int M_RAND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_a = 1'b0, busy_a, ack_a, load_a, shift_a, chain_a;
    logic [31:0] cmd_a = 32'h0, rsp_a, sld_a;
    logic [31:0] sh_a = 32'h0;
    logic        loop_a = 1'b0, drv_a = 1'b0;

    logic        req_b = 1'b0, busy_b, ack_b, load_b, shift_b, chain_b;
    logic [7:0]  cmd_b = 8'h0, rsp_b, sld_b;
    logic [7:0]  sh_b = 8'h0;
    logic        loop_b = 1'b0, drv_b = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    ser_xfer_ctrl #(.WD(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .req(req_a), .cmd_data(cmd_a),
        .busy(busy_a), .ack(ack_a), .rsp_data(rsp_a),
        .ser_load(load_a), .ser_shift(shift_a), .ser_load_data(sld_a),
        .chain_so(chain_a)
    );

    ser_xfer_ctrl #(.WD(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req_b), .cmd_data(cmd_b),
        .busy(busy_b), .ack(ack_b), .rsp_data(rsp_b),
        .ser_load(load_b), .ser_shift(shift_b), .ser_load_data(sld_b),
        .chain_so(chain_b)
    );

    // Shifter stand-ins: load parallel word, shift right, sdo = bit0.
    always @(posedge clk) begin
        if (load_a) sh_a <= sld_a;
        else if (shift_a) sh_a <= {1'b0, sh_a[31:1]};
        if (load_b) sh_b <= sld_b;
        else if (shift_b) sh_b <= {1'b0, sh_b[7:1]};
    end

    assign chain_a = loop_a ? sh_a[0] : drv_a;
    assign chain_b = loop_b ? sh_b[0] : drv_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] obs(input bit w8);
        if (w8) obs = {28'h0, load_b, shift_b, busy_b, ack_b};
        else    obs = {28'h0, load_a, shift_a, busy_a, ack_a};
    endfunction

    function automatic logic [31:0] rsp_of(input bit w8);
        rsp_of = w8 ? {24'h0, rsp_b} : rsp_a;
    endfunction

    function automatic logic [31:0] sld_of(input bit w8);
        sld_of = w8 ? {24'h0, sld_b} : sld_a;
    endfunction

    // Expected {load, shift, busy, ack} in cycle c for a request accepted in cycle s.
    function automatic logic [31:0] exp_vec(input int c, input int s, input int wd);
        int r;
        r = c - s;
        exp_vec = {28'h0, (r == 1), (r >= 2 && r <= wd + 1), (r >= 1 && r <= wd + 2), (r == wd + 2)};
    endfunction

    task automatic set_req(input bit w8, input logic r, input logic [31:0] cmd);
        if (w8) begin req_b = r; cmd_b = cmd[7:0]; end
        else    begin req_a = r; cmd_a = cmd;      end
    endtask

    task automatic set_mode(input bit w8, input int mode);
        if (w8) begin loop_b = (mode == M_LOOP); drv_b = (mode == M_ONE); end
        else    begin loop_a = (mode == M_LOOP); drv_a = (mode == M_ONE); end
    endtask

    task automatic set_drv(input bit w8, input logic b);
        if (w8) drv_b = b;
        else    drv_a = b;
    endtask

    // One full transfer starting at the current negedge (cycle 0).
    task automatic xfer(input bit w8, input logic [31:0] cmd, input int mode,
                        input logic [31:0] exp_in, input bit use_exp, input bit poke);
        int          wd;
        int          acks;
        logic [31:0] mask, model, exp_rsp, prev_rsp, vec;
        logic        b;
        wd       = w8 ? 8 : 32;
        mask     = w8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
        model    = 32'h0;
        acks     = 0;
        prev_rsp = rsp_of(w8);
        set_mode(w8, mode);
        set_req(w8, 1'b1, cmd);
        for (int c = 1; c <= wd + 3; c++) begin
            @(negedge clk);
            if (c == 1) set_req(w8, 1'b0, ~cmd);
            if (poke && c == 10) set_req(w8, 1'b1, cmd ^ 32'h0F0F_0F0F);
            if (poke && c == 11) set_req(w8, 1'b0, cmd);
            vec = obs(w8);
            acks += int'(vec[0]);
            check($sformatf("ctl w8=%0d c=%0d", w8, c), vec, exp_vec(c, 0, wd));
            if (c >= 2 && c <= wd + 1) begin
                if (mode == M_RAND) begin
                    b = 1'($urandom_range(0, 1));
                    set_drv(w8, b);
                end else if (mode == M_LOOP) begin
                    b = cmd[c - 2];
                end else begin
                    b = (mode == M_ONE);
                end
                model[c - 2] = b;
            end
            exp_rsp = use_exp ? exp_in : (model & mask);
            if (c == wd + 1) check("rsp_hold_before_ack", rsp_of(w8), prev_rsp);
            if (c == wd + 2) begin
                check("rsp_at_ack", rsp_of(w8), exp_rsp);
                check("load_data_kept", sld_of(w8), cmd & mask);
            end
            if (c == wd + 3) check("rsp_after_ack", rsp_of(w8), exp_rsp);
        end
        if (poke) begin
            for (int c = 0; c < wd + 3; c++) begin
                @(negedge clk);
                acks += int'(obs(w8) & 32'h1);
            end
        end
        check("ack_count", 32'(acks), 32'd1);
    endtask

    typedef struct {
        bit          w8;
        logic [31:0] cmd;
        int          mode;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          acks;
        bit          w8;
        int          mode;
        logic [31:0] cmd;

        tbl[0] = '{1'b0, 32'hA5C3_0F81, M_LOOP, 32'hA5C3_0F81};
        tbl[1] = '{1'b1, 32'h0000_005A, M_ONE,  32'h0000_00FF};
        tbl[2] = '{1'b1, 32'h0000_003C, M_ZERO, 32'h0000_0000};
        tbl[3] = '{1'b0, 32'h0000_0000, M_ONE,  32'hFFFF_FFFF};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF, M_ZERO, 32'h0000_0000};
        tbl[5] = '{1'b1, 32'h0000_00C3, M_LOOP, 32'h0000_00C3};
        tbl[6] = '{1'b0, 32'h1234_5678, M_LOOP, 32'h1234_5678};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ctl32", obs(1'b0), 32'h0);
        check("rst_ctl8", obs(1'b1), 32'h0);
        check("rst_rsp32", rsp_a, 32'h0);
        check("rst_sld32", sld_a, 32'h0);
        check("rst_rsp8", {24'h0, rsp_b}, 32'h0);
        check("rst_sld8", {24'h0, sld_b}, 32'h0);
        check("rst_state", 32'(u_dut32.state_r), 32'(IDLE));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", obs(1'b0) | obs(1'b1), 32'h0);
        end

        for (int i = 0; i < 7; i++) begin
            xfer(tbl[i].w8, tbl[i].cmd, tbl[i].mode, tbl[i].exp_rsp, 1'b1, 1'b0);
        end

        // Back-to-back with req held high.
        set_mode(1'b0, M_LOOP);
        set_req(1'b0, 1'b1, 32'h0000_0001);
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 1) cmd_a = 32'hFFFF_FFFF;
            check($sformatf("b2b c=%0d", c), obs(1'b0), exp_vec(c, 0, 32) | exp_vec(c, 35, 32));
            if (c == 34) check("b2b_rsp1", rsp_a, 32'h0000_0001);
            if (c == 36) begin
                check("b2b_sld2", sld_a, 32'hFFFF_FFFF);
                req_a = 1'b0;
            end
            if (c == 68) check("b2b_rsp1_held", rsp_a, 32'h0000_0001);
            if (c == 69) check("b2b_rsp2", rsp_a, 32'hFFFF_FFFF);
        end

        // Request while busy is ignored.
        xfer(1'b0, 32'h3C3C_5AA5, M_LOOP, 32'h3C3C_5AA5, 1'b1, 1'b1);

        // Reset mid-SHIFT discards the transfer.
        set_mode(1'b0, M_LOOP);
        set_req(1'b0, 1'b1, 32'hDEAD_BEEF);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) req_a = 1'b0;
        end
        check("pre_rst_shift", obs(1'b0), 32'h4 | 32'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", obs(1'b0), 32'h0);
        check("mid_rst_state", 32'(u_dut32.state_r), 32'(IDLE));
        check("mid_rst_sld", sld_a, 32'h0);
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            acks += int'(ack_a);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            acks += int'(ack_a);
        end
        check("mid_rst_no_ack", 32'(acks), 32'd0);
        check("mid_rst_rsp", rsp_a, 32'h0);
        xfer(1'b0, 32'h0BAD_F00D, M_LOOP, 32'h0BAD_F00D, 1'b1, 1'b0);

        // Randomized transfers against the bit-list model.
        for (int i = 0; i < 10; i++) begin
            w8   = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 1) == 0) ? M_RAND : M_LOOP;
            cmd  = $urandom;
            xfer(w8, cmd, mode, 32'h0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
